// File: rtl/lcd_frame_capture.sv
// ============================================================================
// Module  : lcd_frame_capture
// Purpose : Captures one RGB565 LCD frame into a frame buffer on request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_frame_capture #(
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272,
  parameter int ADDR_W = 17
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iLcdClkEn,
  input  logic              iLcdHSync,
  input  logic              iLcdVSync,
  input  logic              iLcdDe,
  input  logic [4:0]        iLcdR,
  input  logic [5:0]        iLcdG,
  input  logic [4:0]        iLcdB,
  input  logic              iArm,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [15:0]       oWrData,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oErr,
  output logic [8:0]        oLineCnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } stateT;

  localparam int                  c_pixW     = $clog2(WIDTH + 1);
  localparam logic [c_pixW-1:0]   c_width    = c_pixW'(WIDTH);
  localparam logic [8:0]          c_lastLine = 9'(HEIGHT - 1);
  localparam logic [ADDR_W:0]     c_total    = (ADDR_W + 1)'(WIDTH * HEIGHT);

  stateT               r_state;
  stateT               w_stateNext;
  logic                r_prevHs;
  logic                r_prevVs;
  logic                r_prevDe;
  logic                r_wrEn;
  logic [ADDR_W-1:0]   r_wrAddr;
  logic [15:0]         r_wrData;
  logic                r_err;
  logic [8:0]          r_lineCnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_pixW-1:0]   r_pixCnt;
  logic                w_busy;
  logic                w_frameDone;
  logic                w_vsFall;
  logic                w_deFall;
  logic                w_pixel;
  logic                w_frameEnd;
  logic                w_roomInLine;
  logic                w_unused;

  // Edges are judged only between consecutive strobed samples.
  assign w_vsFall     = iLcdClkEn & r_prevVs & ~iLcdVSync;
  assign w_deFall     = iLcdClkEn & r_prevDe & ~iLcdDe;
  assign w_pixel      = iLcdClkEn & iLcdDe;
  assign w_frameEnd   = w_deFall && (r_lineCnt == c_lastLine);
  assign w_roomInLine = (r_pixCnt < c_width) && ({1'b0, r_addr} < c_total);

  // HSync history is retained for completeness; line timing keys on DE.
  assign w_unused = r_prevHs;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= IDLE;
      r_prevHs  <= 1'b1;
      r_prevVs  <= 1'b1;
      r_prevDe  <= 1'b0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_err     <= 1'b0;
      r_lineCnt <= '0;
      r_addr    <= '0;
      r_pixCnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_wrEn  <= 1'b0;
      if (iLcdClkEn) begin
        r_prevHs <= iLcdHSync;
        r_prevVs <= iLcdVSync;
        r_prevDe <= iLcdDe;
      end
      case (r_state)
        IDLE: begin
          if (iArm) begin
            r_err     <= 1'b0;
            r_lineCnt <= '0;
          end
        end
        WAIT_VS: begin
          if (w_vsFall) begin
            r_addr   <= '0;
            r_pixCnt <= '0;
          end
        end
        ACTIVE: begin
          // Frame completion outranks a coincident VSync restart.
          if (w_frameEnd) begin
            r_lineCnt <= r_lineCnt + 9'd1;
            if (r_pixCnt != c_width) r_err <= 1'b1;
            r_pixCnt <= '0;
          end else if (w_vsFall) begin
            r_err     <= 1'b1;
            r_addr    <= '0;
            r_lineCnt <= '0;
            r_pixCnt  <= '0;
          end else if (w_deFall) begin
            r_lineCnt <= r_lineCnt + 9'd1;
            if (r_pixCnt != c_width) r_err <= 1'b1;
            r_pixCnt <= '0;
          end else if (w_pixel) begin
            if (w_roomInLine) begin
              r_wrEn   <= 1'b1;
              r_wrAddr <= r_addr;
              r_wrData <= {iLcdR, iLcdG, iLcdB};
              r_addr   <= r_addr + ADDR_W'(1);
              r_pixCnt <= r_pixCnt + c_pixW'(1);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (iArm) w_stateNext = WAIT_VS;
      end
      WAIT_VS: begin
        w_busy = 1'b1;
        if (w_vsFall) w_stateNext = ACTIVE;
      end
      ACTIVE: begin
        w_busy = 1'b1;
        if (w_frameEnd) w_stateNext = DONE;
      end
      DONE: begin
        w_frameDone = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign oWrEn      = r_wrEn;
  assign oWrAddr    = r_wrAddr;
  assign oWrData    = r_wrData;
  assign oBusy      = w_busy;
  assign oFrameDone = w_frameDone;
  assign oErr       = r_err;
  assign oLineCnt   = r_lineCnt;

endmodule

`default_nettype wire

// File: tb/tb_lcd_frame_capture.sv
// ============================================================================
// Module  : tb_lcd_frame_capture
// Purpose : Randomised frame-level bench for lcd_frame_capture.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_frame_capture;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int AW   = 6;
  localparam int MAXL = 24;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          iLcdClkEn = 1'b0;
  logic          iLcdHSync = 1'b1;
  logic          iLcdVSync = 1'b1;
  logic          iLcdDe = 1'b0;
  logic [4:0]    iLcdR = '0;
  logic [5:0]    iLcdG = '0;
  logic [4:0]    iLcdB = '0;
  logic          iArm = 1'b0;
  logic          oWrEn;
  logic [AW-1:0] oWrAddr;
  logic [15:0]   oWrData;
  logic          oBusy;
  logic          oFrameDone;
  logic          oErr;
  logic [8:0]    oLineCnt;

  lcd_frame_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .iClk(iClk), .iRst(iRst), .iLcdClkEn(iLcdClkEn), .iLcdHSync(iLcdHSync),
    .iLcdVSync(iLcdVSync), .iLcdDe(iLcdDe), .iLcdR(iLcdR), .iLcdG(iLcdG),
    .iLcdB(iLcdB), .iArm(iArm), .oWrEn(oWrEn), .oWrAddr(oWrAddr),
    .oWrData(oWrData), .oBusy(oBusy), .oFrameDone(oFrameDone), .oErr(oErr),
    .oLineCnt(oLineCnt)
  );

  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nErrors = 0;

  // Frame description and the pixels actually sent per line.
  int          lineLen [MAXL];
  int          nLines;
  int          earlyAt;
  int          armPulseAt;
  logic [15:0] pix [MAXL][$];
  logic [AW+15:0] expQ[$];
  logic [AW+15:0] actQ[$];
  int          expErr;
  int          expLines;
  int          doneCnt;
  int          badWr;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (oWrEn) actQ.push_back({oWrAddr, oWrData});
    if (oWrEn && !oBusy) badWr++;
    if (oFrameDone) doneCnt++;
  end

  task automatic sample(input logic hs, input logic vs, input logic de, input logic [15:0] px);
    iLcdHSync = hs; iLcdVSync = vs; iLcdDe = de;
    {iLcdR, iLcdG, iLcdB} = px;
    iLcdClkEn = 1'b1;
    @(posedge iClk); #1;
    iLcdClkEn = 1'b0;
    // Junk between strobes must be ignored by the capture.
    repeat ($urandom_range(0, 2)) begin
      {iLcdHSync, iLcdVSync, iLcdDe} = 3'($urandom);
      {iLcdR, iLcdG, iLcdB} = 16'($urandom);
      @(posedge iClk); #1;
    end
  endtask

  task automatic vsyncPulse();
    sample(1'b1, 1'b1, 1'b0, 16'($urandom));
    sample(1'b1, 1'b0, 1'b0, 16'($urandom));
    sample(1'b1, 1'b0, 1'b0, 16'($urandom));
    sample(1'b1, 1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic sendLine(input int li, input bit vsAtEnd);
    logic [15:0] p;
    for (int j = 0; j < lineLen[li]; j++) begin
      p = 16'($urandom);
      pix[li].push_back(p);
      sample(1'b1, 1'b1, 1'b1, p);
    end
    sample(1'b1, !vsAtEnd, 1'b0, 16'($urandom));
    sample(1'b1, !vsAtEnd, 1'b0, 16'($urandom));
    sample(1'b0, 1'b1, 1'b0, 16'($urandom));
    sample(1'b1, 1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic arm();
    iArm = 1'b1;
    repeat (2) begin @(posedge iClk); #1; end
    iArm = 1'b0;
  endtask

  task automatic prepare();
    for (int i = 0; i < MAXL; i++) begin
      pix[i].delete();
      lineLen[i] = W;
    end
    actQ.delete();
    doneCnt = 0; badWr = 0; earlyAt = -1; armPulseAt = -1;
  endtask

  task automatic runFrame(input bit coincideLast);
    vsyncPulse();
    for (int li = 0; li < nLines; li++) begin
      if (li == earlyAt) vsyncPulse();
      if (li == armPulseAt) begin
        iArm = 1'b1; @(posedge iClk); #1; iArm = 1'b0;
      end
      sendLine(li, coincideLast && (li == nLines - 1));
    end
    repeat (10) begin @(posedge iClk); #1; end
  endtask

  // Reference: walk the sent lines; each line writes its first W pixels at
  // consecutive addresses, an early VSync restarts, H finished lines end it.
  task automatic buildExp();
    int addr = 0;
    int lines = 0;
    expQ.delete();
    expErr = 0;
    for (int li = 0; li < nLines; li++) begin
      if (lines == H) break;
      if (li == earlyAt) begin
        expErr = 1; addr = 0; lines = 0;
      end
      for (int j = 0; j < pix[li].size(); j++) begin
        if (j < W) begin
          expQ.push_back({AW'(addr), pix[li][j]});
          addr++;
        end else begin
          expErr = 1;
        end
      end
      if (pix[li].size() != W) expErr = 1;
      lines++;
    end
    expLines = lines;
  endtask

  task automatic score(input string name, input int eDone, input int eErr, input int eLines);
    int mism = 0;
    for (int i = 0; i < expQ.size(); i++)
      if (i >= actQ.size() || actQ[i] !== expQ[i]) begin
        if (mism == 0)
          $display("FAIL %s.first_bad_write idx=%0d got %0h expected %0h", name, i,
                   (i < actQ.size()) ? actQ[i] : '0, expQ[i]);
        mism++;
      end
    checkVal({name, ".nwr"}, 64'(actQ.size()), 64'(expQ.size()));
    checkVal({name, ".wrseq"}, 64'(mism), 64'd0);
    checkVal({name, ".done"}, 64'(doneCnt), 64'(eDone));
    checkVal({name, ".err"}, 64'(oErr), 64'(eErr));
    checkVal({name, ".lines"}, 64'(oLineCnt), 64'(eLines));
    checkVal({name, ".idle"}, 64'(oBusy), 64'd0);
    checkVal({name, ".wr_outside"}, 64'(badWr), 64'd0);
  endtask

  task automatic frameScenario(input string name, input bit coincideLast);
    arm();
    runFrame(coincideLast);
    buildExp();
    score(name, 1, expErr, expLines);
  endtask

  initial begin
    logic [15:0] p;
    int kind;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    checkVal("reset_outs", 64'({oWrEn, oWrAddr, oWrData, oBusy, oFrameDone, oErr, oLineCnt}), 64'd0);

    prepare(); nLines = H + 1;
    frameScenario("nominal", 1'b0);

    prepare(); nLines = H + 1; lineLen[2] = W - 1;
    frameScenario("short_line", 1'b0);

    prepare(); nLines = H + 1; lineLen[0] = W + 1;
    frameScenario("long_line", 1'b0);

    prepare(); earlyAt = 3; nLines = 3 + H + 1;
    frameScenario("early_vs", 1'b0);

    prepare(); nLines = H;
    frameScenario("vs_on_last_line", 1'b1);

    // DE and VSync activity before arming and before the first VSync.
    prepare(); nLines = H + 1; armPulseAt = 2;
    sendLine(MAXL - 1, 1'b0);
    vsyncPulse();
    arm();
    sendLine(MAXL - 2, 1'b0);
    runFrame(1'b0);
    buildExp();
    score("arm_timing", 1, expErr, expLines);

    // Reset arriving together with a valid pixel part way into line 1.
    prepare(); nLines = 2; lineLen[1] = 3;
    arm();
    vsyncPulse();
    sendLine(0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      p = 16'($urandom);
      pix[1].push_back(p);
      sample(1'b1, 1'b1, 1'b1, p);
    end
    iLcdHSync = 1'b1; iLcdVSync = 1'b1; iLcdDe = 1'b1;
    {iLcdR, iLcdG, iLcdB} = 16'($urandom);
    iLcdClkEn = 1'b1; iRst = 1'b1;
    @(posedge iClk); #1;
    iLcdClkEn = 1'b0; iRst = 1'b0;
    checkVal("midrst.outs", 64'({oWrEn, oWrAddr, oWrData, oBusy, oFrameDone, oErr, oLineCnt}), 64'd0);
    @(posedge iClk); #1;
    checkVal("midrst.no_write_after", 64'(oWrEn), 64'd0);
    vsyncPulse();
    for (int li = 2; li < 2 + H; li++) sendLine(li, 1'b0);
    repeat (10) begin @(posedge iClk); #1; end
    buildExp();
    score("midrst", 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      prepare();
      kind = $urandom_range(0, 3);
      nLines = H + 1;
      if (kind == 1) lineLen[$urandom_range(0, H - 1)] = W - 1;
      if (kind == 2) lineLen[$urandom_range(0, H - 1)] = W + 1;
      if (kind == 3) begin
        earlyAt = $urandom_range(1, H - 1);
        nLines = earlyAt + H + 1;
      end
      frameScenario($sformatf("rand%0d_k%0d", k, kind), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
